subtractor_serial_8bit: RTL
===========================

# subtractor_serial_8bit

Bit-serial 8-bit subtractor with borrow-in and borrow-out. It computes dif = min − sub − preB one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It sits next to the combinational adder blocks as the area-lean, multi-cycle counterpart for datapaths that can tolerate latency. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse.

## Interface
- No parameters; width fixed at 8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled at rising edge, accepted only in IDLE or DONE.
- min  input  8  minuend; captured on accepted start.
- sub  input  8  subtrahend; captured on accepted start.
- preB  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in SHIFT.
- done  output  1  one-cycle pulse; result valid and updated.
- dif  output  8  difference; held from completion until next completion.
- proB  output  1  borrow-out of bit 7; held with dif.
- ovf  output  1  two's-complement overflow; held with dif.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- Internal registers: opA[7:0], opB[7:0], acc[7:0] shift register, bw borrow flop, cnt[2:0], a7/b7 sign copies.
- IDLE/DONE with start=1: opA<=min, opB<=sub, bw<=preB, cnt<=0, a7<=min[7], b7<=sub[7]; go to SHIFT.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- SHIFT, per cycle, with a=opA[0] and b=opB[0]:
  - d=a^b^bw
  - bw<=(~a&b)|(~(a^b)&bw)
  - acc<={d,acc[7:1]}
  - opA, opB shift right one bit
  - cnt<=cnt+1
- SHIFT with cnt==7: go to DONE. On the same edge, dif<={d,acc[7:1]}, proB<=next bw, ovf<=(a7!=b7)&&(d!=a7).
- start during SHIFT is ignored. No queueing, and operands are not re-captured.
- min, sub and preB are don't-care except on the accepting edge.
- dif, proB and ovf change only on the SHIFT→DONE edge and on reset. They never show partial results.
- Arithmetic is modulo 256. proB=1 iff the unsigned min < sub+preB.
- Reset asserted at any time, including mid-SHIFT:
  - Immediately forces IDLE.
  - Forces busy=done=0, dif=0x00, proB=0, ovf=0, and clears all internal registers.
  - The in-flight operation is discarded. Release takes effect at the next clock edge.

## Timing
- Reset values: busy=0, done=0, dif=0x00, proB=0, ovf=0.
- busy=1 exactly when state==SHIFT. done=1 exactly when state==DONE.
- Start accepted at edge N:
  - busy is high for cycles N..N+7, i.e. asserted after edge N and deasserted after edge N+8.
  - Results update at edge N+8. done is high for the cycle after edge N+8.
  - Latency is 8 clocks from the accepting edge to result valid.
- Back-to-back: start=1 sampled in the DONE cycle (edge N+9) is accepted. Sustained throughput is one result per 9 clocks.
  - The previous dif/proB/ovf stay held until edge N+17.
- Start sampled in the DONE cycle does not extend done; done is still a single cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-clock with no edge → all outputs 0 immediately. Release, then idle 5 cycles → busy=0, done=0.
- min=0x50, sub=0x20, preB=0, start at edge N → busy cycles N..N+7. done after edge N+8 with dif=0x30, proB=0, ovf=0.
- Borrow cases:
  - min=0x00, sub=0x01, preB=0 → dif=0xFF, proB=1, ovf=0.
  - min=0x10, sub=0x0F, preB=1 → dif=0x00, proB=0, ovf=0.
- Signed overflow: min=0x80, sub=0x01, preB=0 → dif=0x7F, proB=0, ovf=1. Then min=0x7F, sub=0xFF → dif=0x80, proB=1, ovf=1.
- Handshake: start with min=0x05, sub=0x03. Pulse start with min=0xAA at cycle N+3 → ignored, dif=0x02. Start in the DONE cycle with min=0x09, sub=0x09 → accepted, done 9 cycles later with dif=0x00.
- Reset mid-operation: start 0x50−0x20, then drop rst_n at cycle N+4 → busy=0, dif=0x00 immediately, no done pulse. After release, start 0x03−0x01 → dif=0x02 at the normal latency.

Source files
------------

// File: rtl/subtractor_serial_8bit.sv
// Bit-serial 8-bit subtractor: dif = min - sub - preB, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; last result held on dif/proB/ovf
// SHIFT | processing one bit per clock, cnt counts 0..7
// DONE  | one-cycle result-valid pulse; a new start is accepted here too
module subtractor_serial_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] min,
  input  logic [7:0] sub,
  input  logic       preB,
  output logic       busy,
  output logic       done,
  output logic [7:0] dif,
  output logic       proB,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] acc;
  logic       bw;
  logic [2:0] cnt;
  logic       a7;
  logic       b7;

  logic       bit_a;
  logic       bit_b;
  logic       bit_d;
  logic       bw_nxt;
  logic       load;
  logic       last_bit;

  // Full-subtractor cell on the current LSBs, plus handshake/terminal decode.
  always_comb begin
    bit_a    = op_a[0];
    bit_b    = op_b[0];
    bit_d    = bit_a ^ bit_b ^ bw;
    bw_nxt   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw);
    load     = start && ((state == IDLE) || (state == DONE));
    last_bit = (cnt == 3'd7);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start during SHIFT is deliberately ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

  // Operand capture, serial shift, and result commit on the final bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= 8'h00;
      op_b <= 8'h00;
      acc  <= 8'h00;
      bw   <= 1'b0;
      cnt  <= 3'd0;
      a7   <= 1'b0;
      b7   <= 1'b0;
      dif  <= 8'h00;
      proB <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      op_a <= min;
      op_b <= sub;
      bw   <= preB;
      cnt  <= 3'd0;
      a7   <= min[7];
      b7   <= sub[7];
    end else if (state == SHIFT) begin
      op_a <= {1'b0, op_a[7:1]};
      op_b <= {1'b0, op_b[7:1]};
      acc  <= {bit_d, acc[7:1]};
      bw   <= bw_nxt;
      cnt  <= cnt + 3'd1;
      if (last_bit) begin
        dif  <= {bit_d, acc[7:1]};
        proB <= bw_nxt;
        ovf  <= (a7 != b7) && (bit_d != a7);
      end
    end
  end

endmodule
